// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

   localparam int          PC_W    = 32;
   localparam int          INSTR_W = 32;
   localparam int          ENTRY_W = PC_W + INSTR_W;
   localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of {pc, instruction} entries; flush clears it in one cycle.
module instr_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        push,
   input  logic                        pop,
   input  logic [ENTRY_W-1:0]          wdata,
   output logic [ENTRY_W-1:0]          rdata,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           wr_en, rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= fetch_entry_t'(wdata);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: issues word fetches, buffers responses, handles redirects.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets into FAULT.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pc_q, rsp_pc_q, tgt_pc;
   logic [CW-1:0]    out_q, out_d, disc_q, fifo_count;
   logic [CW:0]      inflight;
   logic             tgt_fault, req_fire, rsp_any, push, pop;
   logic             fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] head_raw;
   fetch_entry_t     head;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign tgt_fault   = (redirect_pc[1:0] != 2'b00);
   assign tgt_pc      = redirect_pc;
   assign fetch_fault = (state_q == FAULT);
`else
   assign tgt_fault   = 1'b0;
   assign tgt_pc      = redirect_pc & 32'hFFFF_FFFC;
   assign fetch_fault = 1'b0;
`endif

   // Buffered plus in-flight never exceeds the FIFO, so responses always land.
   assign inflight       = {1'b0, fifo_count} + {1'b0, out_q};
   assign imem_req_valid = rst_n && (state_q == RUN) && !fifo_full
                           && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding belongs to a pre-reset request.
   assign rsp_any = imem_rsp_valid && (out_q != '0);
   assign push    = rsp_any && (disc_q == '0) && !redirect_valid;

   assign head        = fetch_entry_t'(head_raw);
   assign instr_valid = (state_q == RUN) && !fifo_empty;
   assign pop         = instr_valid && instr_ready && !redirect_valid;
   assign instruction = instr_valid ? head.instr : '0;
   assign instr_pc    = instr_valid ? head.pc : '0;

   always_comb begin
      out_d = out_q;
      case ({req_fire, rsp_any})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) state_d = tgt_fault ? FAULT : RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         out_q    <= '0;
         disc_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         if (redirect_valid) begin
            // Everything still in flight, including this cycle's accept, is stale.
            pc_q     <= tgt_pc;
            rsp_pc_q <= tgt_pc;
            disc_q   <= out_d;
         end else begin
            if (req_fire) pc_q <= pc_q + 32'd4;
            if (push) rsp_pc_q <= rsp_pc_q + 32'd4;
            if (rsp_any && (disc_q != '0)) disc_q <= disc_q - 1'b1;
         end
      end
   end

   instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata ({rsp_pc_q, imem_rsp_data}),
      .rdata (head_raw),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-configurable in-order memory model.
module tb_instr_fetch;

   localparam logic [31:0] K = 32'h00C0_0293;  // mem word = addr + K, so word @0 is ADDI x5,x0,12

   logic        clk, rst_n;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        instr_valid, instr_ready, redirect_valid, fetch_fault;
   logic [31:0] instruction, instr_pc, redirect_pc;

   int checks = 0, passed = 0, lat = 1, cyc = 0;
   logic        fire_pend = 1'b0;
   logic [31:0] fire_addr = '0;
   logic [31:0] req_log[$], pop_pc[$], pop_ins[$], mq_addr[$];
   int          mq_due[$];

   instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observe handshakes mid-cycle; inputs only move just after the rising edge.
   always @(negedge clk) begin
      fire_pend = rst_n && imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      if (fire_pend) req_log.push_back(imem_req_addr);
      if (instr_valid && instr_ready) begin
         pop_pc.push_back(instr_pc);
         pop_ins.push_back(instruction);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq_addr.delete();
         mq_due.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
         cyc            <= 0;
      end else begin
         cyc            <= cyc + 1;
         imem_rsp_valid <= 1'b0;
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mq_addr[0] + K;
            mq_addr.pop_front();
            mq_due.pop_front();
         end
         if (fire_pend) begin
            mq_addr.push_back(fire_addr);
            mq_due.push_back(cyc + lat);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      req_log.delete();
      pop_pc.delete();
      pop_ins.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      instr_ready = 1'b0; imem_req_ready = 1'b1; lat = 1;
      tick(); tick();
      clear_logs();
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_pops(input int n, input int budget, input string tag);
      int i = 0;
      while (pop_pc.size() < n && i < budget) begin tick(); i++; end
      if (pop_pc.size() < n) begin
         checks++;
         $display("FAIL %s_timeout: got %0d pops, need %0d", tag, pop_pc.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      instr_ready = 1'b0; imem_req_ready = 1'b1; lat = 1;
      #3; tick();
      checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else passed++;
      checks++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else passed++;
      checks++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fetch_fault); else passed++;
      checks++; if (instruction !== 32'h0) $display("FAIL rst_instruction: got %h want 0", instruction); else passed++;
      checks++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc); else passed++;
      clear_logs();
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1) $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); else passed++;
      checks++; if (imem_req_addr !== 32'h0) $display("FAIL rel_req_addr: got %h want 0", imem_req_addr); else passed++;
   endtask

   task automatic test_stream();
      do_reset();
      instr_ready = 1'b1;
      wait_pops(3, 30, "stream");
      checks++; if (req_log[0] !== 32'h0) $display("FAIL stream_req0: got %h want 0", req_log[0]); else passed++;
      checks++; if (req_log[1] !== 32'h4) $display("FAIL stream_req1: got %h want 4", req_log[1]); else passed++;
      checks++; if (req_log[2] !== 32'h8) $display("FAIL stream_req2: got %h want 8", req_log[2]); else passed++;
      checks++; if (pop_pc[0] !== 32'h0) $display("FAIL stream_pc0: got %h want 0", pop_pc[0]); else passed++;
      checks++; if (pop_pc[1] !== 32'h4) $display("FAIL stream_pc1: got %h want 4", pop_pc[1]); else passed++;
      checks++; if (pop_pc[2] !== 32'h8) $display("FAIL stream_pc2: got %h want 8", pop_pc[2]); else passed++;
      checks++; if (pop_ins[2] !== 32'h00C0_029B) $display("FAIL stream_ins2: got %h want 00c0029b", pop_ins[2]); else passed++;
   endtask

   task automatic test_stall();
      do_reset();
      repeat (10) tick();
      checks++; if (req_log.size() != 2) $display("FAIL stall_reqs: got %0d want 2", req_log.size()); else passed++;
      checks++; if (instr_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", instr_valid); else passed++;
      checks++; if (instruction !== 32'h00C0_0293) $display("FAIL stall_head: got %h want 00c00293", instruction); else passed++;
      instr_ready = 1'b1;
      wait_pops(3, 30, "stall");
      checks++; if (pop_ins[0] !== 32'h00C0_0293) $display("FAIL stall_first: got %h want 00c00293", pop_ins[0]); else passed++;
      checks++; if (pop_pc[1] !== 32'h4) $display("FAIL stall_pc1: got %h want 4", pop_pc[1]); else passed++;
      checks++; if (pop_ins[1] !== 32'h00C0_0297) $display("FAIL stall_ins1: got %h want 00c00297", pop_ins[1]); else passed++;
      checks++; if (pop_pc[2] !== 32'h8) $display("FAIL stall_pc2: got %h want 8", pop_pc[2]); else passed++;
   endtask

   task automatic test_redirect();
      int i = 0;
      do_reset();
      lat = 3;
      repeat (12) tick();
      checks++; if (instr_valid !== 1'b1) $display("FAIL redir_prefill: got %b want 1", instr_valid); else passed++;
      redirect(32'h200);
      checks++; if (instr_valid !== 1'b0) $display("FAIL redir_flush: got %b want 0", instr_valid); else passed++;
      checks++; if (imem_req_addr !== 32'h200) $display("FAIL redir_addr: got %h want 200", imem_req_addr); else passed++;
      clear_logs();
      while (req_log.size() < 2 && i < 20) begin tick(); i++; end
      checks++; if (req_log[1] !== 32'h204) $display("FAIL redir_inflight: got %h want 204", req_log[1]); else passed++;
      redirect(32'h100);
      instr_ready = 1'b1;
      wait_pops(1, 40, "redir");
      checks++; if (pop_pc[0] !== 32'h100) $display("FAIL redir_pc: got %h want 100", pop_pc[0]); else passed++;
      checks++; if (pop_ins[0] !== 32'h00C0_0393) $display("FAIL redir_ins: got %h want 00c00393", pop_ins[0]); else passed++;
   endtask

   task automatic test_backpressure();
      do_reset();
      instr_ready = 1'b1;
      imem_req_ready = 1'b0;
      tick();
      redirect(32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL bp_hold%0d: got %h want fffffffc", i, imem_req_addr); else passed++;
         checks++; if (imem_req_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, imem_req_valid); else passed++;
         tick();
      end
      clear_logs();
      imem_req_ready = 1'b1;
      wait_pops(2, 30, "bp");
      checks++; if (req_log[0] !== 32'hFFFF_FFFC) $display("FAIL bp_req0: got %h want fffffffc", req_log[0]); else passed++;
      checks++; if (req_log[1] !== 32'h0) $display("FAIL bp_wrap: got %h want 0", req_log[1]); else passed++;
      checks++; if (pop_pc[1] !== 32'h0) $display("FAIL bp_pc1: got %h want 0", pop_pc[1]); else passed++;
   endtask

   task automatic test_misalign();
      do_reset();
      instr_ready = 1'b1;
      repeat (4) tick();
      redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++; if (fetch_fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", fetch_fault); else passed++;
      clear_logs();
      repeat (6) tick();
      checks++; if (req_log.size() != 0) $display("FAIL mis_noreq: got %0d reqs want 0", req_log.size()); else passed++;
      checks++; if (instr_valid !== 1'b0) $display("FAIL mis_valid: got %b want 0", instr_valid); else passed++;
      redirect(32'h300);
      checks++; if (fetch_fault !== 1'b0) $display("FAIL mis_clear: got %b want 0", fetch_fault); else passed++;
      clear_logs();
      wait_pops(1, 30, "mis");
      checks++; if (pop_pc[0] !== 32'h300) $display("FAIL mis_resume: got %h want 300", pop_pc[0]); else passed++;
`else
      checks++; if (fetch_fault !== 1'b0) $display("FAIL mis_fault: got %b want 0", fetch_fault); else passed++;
      checks++; if (imem_req_addr !== 32'h100) $display("FAIL mis_addr: got %h want 100", imem_req_addr); else passed++;
      clear_logs();
      wait_pops(1, 30, "mis");
      checks++; if (req_log[0] !== 32'h100) $display("FAIL mis_req: got %h want 100", req_log[0]); else passed++;
      checks++; if (pop_pc[0] !== 32'h100) $display("FAIL mis_resume: got %h want 100", pop_pc[0]); else passed++;
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (8) tick();
      checks++; if (instr_valid !== 1'b1) $display("FAIL arst_pre: got %b want 1", instr_valid); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) $display("FAIL arst_req: got %b want 0", imem_req_valid); else passed++;
      checks++; if (instr_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", instr_valid); else passed++;
      checks++; if (instruction !== 32'h0) $display("FAIL arst_ins: got %h want 0", instruction); else passed++;
      checks++; if (instr_pc !== 32'h0) $display("FAIL arst_pc: got %h want 0", instr_pc); else passed++;
      tick(); tick();
      clear_logs();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      wait_pops(1, 30, "arst");
      checks++; if (req_log[0] !== 32'h0) $display("FAIL arst_refetch: got %h want 0", req_log[0]); else passed++;
      checks++; if (pop_pc[0] !== 32'h0) $display("FAIL arst_pop: got %h want 0", pop_pc[0]); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_backpressure();
      test_misalign();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
